// File: rtl/sign_narrow_packer_pkg.sv
// Shared definitions for the sign-narrowing packer.
//   IN_W / NARROW_W / LANES : sample width, field width, fields per packed word
//   state_e                 : packer FSM encoding (fill lanes / hold packed word)
//   SAT_POS / SAT_NEG       : field codes used when an overflowing sample saturates
package sign_narrow_packer_pkg;

    localparam int unsigned IN_W     = 8;
    localparam int unsigned NARROW_W = 2;
    localparam int unsigned LANES    = IN_W / NARROW_W;

    typedef enum logic {
        StFill = 1'b0,
        StHold = 1'b1
    } state_e;

    localparam logic [NARROW_W-1:0] SAT_POS = 2'b01;
    localparam logic [NARROW_W-1:0] SAT_NEG = 2'b10;

endpackage

// File: rtl/sign_narrow_packer_sign_narrow.sv
// sign_narrow: combinational narrowing of one signed IN_W-bit sample to a
// NARROW_W-bit signed field.
//   in_data : signed input sample
//   field   : narrowed field
//   ovf     : sample does not fit in NARROW_W signed bits
// Build option NARROW_SAT_EN: overflowing samples saturate to +1 / -2;
// without it they truncate to the low NARROW_W bits.
module sign_narrow
    import sign_narrow_packer_pkg::*;
(
    input  logic [IN_W-1:0]     in_data,
    output logic [NARROW_W-1:0] field,
    output logic                ovf
);

    // The value fits when every bit from the field's sign bit upward is a copy of it.
    logic [IN_W-NARROW_W:0] upper;
    logic                   fits;

    assign upper = in_data[IN_W-1:NARROW_W-1];
    assign fits  = (&upper) | ~(|upper);

    always_comb begin
        ovf = ~fits;
`ifdef NARROW_SAT_EN
        if (fits) begin
            field = in_data[NARROW_W-1:0];
        end else if (in_data[IN_W-1]) begin
            field = SAT_NEG;
        end else begin
            field = SAT_POS;
        end
`else
        field = in_data[NARROW_W-1:0];
`endif
    end

endmodule

// File: rtl/sign_narrow_packer.sv
// sign_narrow_packer: narrows a stream of signed 8-bit samples to 2-bit fields
// and packs four of them per output word (lane 0 in the low bits).
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : input sample handshake, in_data is the sample
//   flush                 : emit a partially filled word
//   out_valid/out_ready   : packed word handshake; out_data, out_count (valid lanes)
//   ovf_sticky / ovf_clr  : sticky overflow flag and its clear (set wins)
// Build option NARROW_SAT_EN selects saturation in the sign_narrow sub-module.
module sign_narrow_packer
    import sign_narrow_packer_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IN_W-1:0] out_data,
    output logic [2:0]      out_count,
    output logic            ovf_sticky,
    input  logic            ovf_clr
);

    state_e            state_q, state_d;
    logic [1:0]        lane_idx_q, lane_idx_d;
    logic [IN_W-1:0]   lane_q, lane_d;
    logic [IN_W-1:0]   out_data_q, out_data_d;
    logic [2:0]        out_count_q, out_count_d;
    logic              ovf_q, ovf_d;

    logic [NARROW_W-1:0] field;
    logic                ovf;
    logic                accept;
    logic [2:0]          cnt_next;

    sign_narrow u_sign_narrow (
        .in_data (in_data),
        .field   (field),
        .ovf     (ovf)
    );

    // Ready is held low while reset is asserted even though the state is already FILL.
    assign in_ready   = rst_n & (state_q == StFill);
    assign out_valid  = (state_q == StHold);
    assign out_data   = out_data_q;
    assign out_count  = out_count_q;
    assign ovf_sticky = ovf_q;

    assign accept   = in_valid & (state_q == StFill);
    // Lane count including a sample accepted on this edge; flush uses this value.
    assign cnt_next = {1'b0, lane_idx_q} + {2'b00, accept};

    always_comb begin
        state_d     = state_q;
        lane_idx_d  = lane_idx_q;
        lane_d      = lane_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;

        if (accept && ovf) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        case (state_q)
            StFill: begin
                if (accept) begin
                    lane_d[lane_idx_q*NARROW_W +: NARROW_W] = field;
                    lane_idx_d = lane_idx_q + 2'd1;
                end
                if (accept && (lane_idx_q == 2'(LANES - 1))) begin
                    state_d     = StHold;
                    out_data_d  = lane_d;
                    out_count_d = 3'(LANES);
                end else if (flush && (cnt_next != 3'd0)) begin
                    state_d     = StHold;
                    out_data_d  = lane_d;
                    out_count_d = cnt_next;
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d     = StFill;
                    lane_idx_d  = 2'd0;
                    lane_d      = '0;
                    out_data_d  = '0;
                    out_count_d = 3'd0;
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StFill;
            lane_idx_q  <= 2'd0;
            lane_q      <= '0;
            out_data_q  <= '0;
            out_count_q <= 3'd0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_idx_q  <= lane_idx_d;
            lane_q      <= lane_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_sign_narrow_packer.sv
// Self-checking bench for sign_narrow_packer: a transaction-level model
// predicts packed words into a scoreboard queue; a negedge monitor compares
// the DUT outputs against the model's handshake state and queue front.
module tb_sign_narrow_packer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       flush = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [2:0] out_count;
    logic       ovf_sticky;
    logic       ovf_clr = 1'b0;

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit m_hold = 1'b0;
    bit m_sticky = 1'b0;
    int m_fields[$];
    int exp_data_q[$];
    int exp_count_q[$];

    sign_narrow_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_count  (out_count),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Narrow a sample by value: fits in [-2, 1], else overflow.
    function automatic int narrow_field(input logic [7:0] d, output bit ov);
        int v;
        v  = int'($signed(d));
        ov = (v < -2) || (v > 1);
`ifdef NARROW_SAT_EN
        if (ov) return (v > 0) ? 1 : 2;
`endif
        return v & 3;
    endfunction

    task automatic emit_word();
        int w;
        w = 0;
        for (int i = 0; i < m_fields.size(); i++) w += m_fields[i] * (4 ** i);
        exp_data_q.push_back(w);
        exp_count_q.push_back(m_fields.size());
        m_fields.delete();
        m_hold = 1'b1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hold = 1'b0;
            m_sticky = 1'b0;
            m_fields.delete();
            exp_data_q.delete();
            exp_count_q.delete();
        end else begin
            bit ov;
            bit acc;
            int f;
            ov  = 1'b0;
            acc = in_valid && !m_hold;
            if (acc) begin
                f = narrow_field(in_data, ov);
                m_fields.push_back(f);
            end
            if (m_hold) begin
                if (out_ready) begin
                    m_hold = 1'b0;
                    void'(exp_data_q.pop_front());
                    void'(exp_count_q.pop_front());
                end
            end else if (m_fields.size() == 4 || (flush && m_fields.size() > 0)) begin
                emit_word();
            end
            if (acc && ov) m_sticky = 1'b1;
            else if (ovf_clr) m_sticky = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_out_count", out_count, 0);
            chk("rst_ovf_sticky", ovf_sticky, 0);
        end else begin
            chk("in_ready", in_ready, !m_hold);
            chk("out_valid", out_valid, m_hold);
            chk("ovf_sticky", ovf_sticky, m_sticky);
            if (m_hold) begin
                if (exp_data_q.size() == 0) begin
                    chk("scoreboard_empty", 1, 0);
                end else begin
                    chk("out_data", out_data, exp_data_q[0]);
                    chk("out_count", out_count, exp_count_q[0]);
                end
            end else begin
                chk("idle_out_data", out_data, 0);
                chk("idle_out_count", out_count, 0);
            end
        end
    end

    task automatic drive(input bit v, input logic [7:0] d, input bit f, input bit r, input bit c);
        in_valid  = v;
        in_data   = d;
        flush     = f;
        out_ready = r;
        ovf_clr   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, r, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic pack -> 0x2D, 4 lanes
        drive(1, 8'h01, 0, 1, 0);
        drive(1, 8'hFF, 0, 1, 0);
        drive(1, 8'hFE, 0, 1, 0);
        drive(1, 8'h00, 0, 1, 0);
        idle(2, 1);

        // Overflow, then clear
        drive(1, 8'h06, 0, 1, 0);
        drive(1, 8'h80, 0, 1, 0);
        drive(1, 8'h00, 0, 1, 0);
        drive(1, 8'h00, 0, 1, 0);
        idle(2, 1);
        drive(0, 8'h00, 0, 1, 1);
        idle(1, 1);

        // Flush of two lanes, then flush with nothing pending
        drive(1, 8'h01, 0, 1, 0);
        drive(1, 8'hFF, 0, 1, 0);
        drive(0, 8'h00, 1, 1, 0);
        idle(2, 1);
        drive(0, 8'h00, 1, 1, 0);
        drive(0, 8'h00, 1, 1, 0);
        idle(1, 1);

        // Backpressure on a full word
        drive(1, 8'h01, 0, 0, 0);
        drive(1, 8'h00, 0, 0, 0);
        drive(1, 8'hFF, 0, 0, 0);
        drive(1, 8'hFE, 0, 0, 0);
        drive(1, 8'h01, 1, 0, 0);
        idle(5, 0);
        idle(2, 1);

        // Flush on the 3rd accept; ovf_clr together with an overflowing accept
        drive(1, 8'hFF, 0, 1, 0);
        drive(1, 8'h01, 0, 1, 0);
        drive(1, 8'hFE, 1, 1, 0);
        idle(2, 1);
        drive(1, 8'h40, 0, 1, 1);
        drive(0, 8'h00, 1, 1, 0);
        idle(2, 1);
        drive(0, 8'h00, 0, 1, 1);

        // Reset in the middle of a fill
        drive(1, 8'h01, 0, 1, 0);
        drive(1, 8'hFF, 0, 1, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1, 8'hFE, 0, 1, 0);
        drive(1, 8'h01, 0, 1, 0);
        drive(1, 8'h00, 0, 1, 0);
        drive(1, 8'hFF, 0, 1, 0);
        idle(2, 1);

        // Randomized traffic, biased toward in-range samples
        for (int i = 0; i < 400; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            if ($urandom_range(0, 2) != 0) d = {{6{d[1]}}, d[1:0]};
            drive(1'($urandom_range(0, 3) != 0), d, ($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
        end

        idle(4, 1);
        chk("drain_empty", exp_data_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sign_narrow_packer.md
# sign_narrow_packer

Sequential narrowing packer: the inverse of the 2-bit to 8-bit sign-extension path. It accepts a stream of 8-bit signed values over a valid/ready handshake. Each value is narrowed to a 2-bit signed field, with overflow detection. Four fields are packed into one 8-bit word and presented downstream over a second valid/ready handshake. It sits on the path that writes 2-bit immediates/operands back into packed 8-bit storage.

## Interface
Parameters:
- IN_W, 8, width of each input sample and of the packed output word
- NARROW_W, 2, width of each narrowed field
- LANES, IN_W/NARROW_W (4), fields per output word; derived, not overridden

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample this cycle
- in_data  in  8  signed input sample
- flush  in  1  emit a partially filled word
- out_valid  out  1  packed word available
- out_ready  in  1  downstream accepts the word
- out_data  out  8  packed word; lane 0 in [1:0], lane 3 in [7:6]
- out_count  out  3  number of valid lanes in out_data (1..4)
- ovf_sticky  out  1  some narrowed sample was out of range since the last clear
- ovf_clr  in  1  clears ovf_sticky

Clock and reset are fixed: one clock, clk; reset rst_n is asynchronous and active-low.

## Operation
- FSM states are FILL and HOLD. Reset enters FILL.
- Handshake rules:
  - in_ready = (state==FILL).
  - out_valid = (state==HOLD).
  - A transfer occurs when valid&&ready on the same rising edge.
- FILL, on input accept:
  - The narrowed field is written into lane lane_idx, then lane_idx increments.
  - If the accepted sample is lane 3, go to HOLD with out_count=4.
- Flush:
  - flush in FILL with lane_idx>0 (counted after any accept on the same edge) goes to HOLD with out_count=lane_idx. Unused lanes read 0.
  - flush with lane_idx==0 and no accept is ignored.
  - flush in HOLD is ignored.
- HOLD:
  - out_data and out_count are held stable while out_ready=0.
  - On out_ready=1, go to FILL and clear lane_idx, the lane register, and out_count.
- Narrowing:
  - A sample fits when in_data[7:1] are all equal. It then maps to in_data[1:0].
  - Otherwise it overflows: ovf_sticky is set, and the field value depends on the Configuration.
- ovf_sticky: a set on the same edge as ovf_clr wins.
- Reset mid-operation discards the partial word and clears everything.

## Timing
- Reset values:
  - in_ready=1 once rst_n deasserts (FILL); 0 while rst_n is low.
  - out_valid=0, out_data=0, out_count=0, ovf_sticky=0.
- Latency: out_valid rises on the cycle after the 4th accept, or after the accepted flush.
- Throughput: at most 4 samples per 5 cycles when out_ready is held at 1.
- There is no combinational path from in_valid or out_ready to in_ready or out_valid. Both are decoded from registered state only.
- out_data is registered and changes only when entering HOLD or leaving it.

## Configuration
- NARROW_SAT_EN defined: an overflowing sample saturates. Positive gives 2'b01 (+1); negative (in_data[7]=1) gives 2'b10 (-2).
- NARROW_SAT_EN undefined: an overflowing sample truncates to in_data[1:0].
- ovf_sticky detection is identical in both builds.

## Structure
- The shared package holds:
  - IN_W, NARROW_W, LANES
  - the FILL/HOLD state encoding
  - the saturation codes SAT_POS=2'b01 and SAT_NEG=2'b10
- One combinational sub-module, sign_narrow: in 8-bit sample; out 2-bit field plus ovf bit. It contains the NARROW_SAT_EN ifdef.
- The top level holds the FSM, lane counter, lane register and sticky flag.

## Test plan
- Basic pack: in_data 0x01, 0xFF, 0xFE, 0x00 with out_ready=1 -> out_data=0x2D, out_count=4, ovf_sticky=0, out_valid for exactly one cycle.
- Overflow: in_data 0x06, 0x80, 0x00, 0x00 -> ovf_sticky=1. out_data=0x09 with NARROW_SAT_EN; 0x02 without. ovf_clr then clears ovf_sticky to 0.
- Flush: in_data 0x01, 0xFF, then flush -> out_data=0x0D, out_count=2. A flush with an empty lane register produces no output.
- Backpressure: a full word with out_ready=0 for 5 cycles -> out_data and out_count stable, in_ready=0 throughout; one cycle after out_ready=1, in_ready=1 and out_valid=0.
- Simultaneous events:
  - flush on the same edge as the 3rd accept -> out_count=3.
  - ovf_clr on the same edge as an overflowing accept -> ovf_sticky=1.
- Reset mid-fill: after 2 accepts, pulse rst_n low -> all outputs at reset values. The next 4 samples form a fresh word with lane 0 in [1:0].
